// File: rtl/gpioled_sched.sv
// gpioled_sched: LED mode controller and ARM override arbiter.
// A debounced mode-step line drives the blink schedule; armgpio[0] forces both LEDs on.
module gpioled_sched #(
  parameter int CNT_W    = 25,
  parameter int SLOW_DIV = 25_000_000,
  parameter int FAST_DIV = 6_250_000,
  parameter int DEB_CYC  = 1_000_000
) (
  input  logic       sclk,
  input  logic       rst,
  input  logic [1:0] armgpio,
  output logic [1:0] led,
  output logic [2:0] mode
);

  typedef enum logic [2:0] {
    M_OFF  = 3'd0,
    M_ON   = 3'd1,
    M_SLOW = 3'd2,
    M_FAST = 3'd3,
    M_ALT  = 3'd4
  } mode_e;

  localparam logic [CNT_W-1:0] SLOW_LAST = CNT_W'(SLOW_DIV - 1);
  localparam logic [CNT_W-1:0] FAST_LAST = CNT_W'(FAST_DIV - 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [1:0]       r_s0;
  logic [1:0]       r_s1;
  logic [1:0]       r_s2;
  logic             r_stable;
  logic             r_stable_d;
  logic [CNT_W-1:0] r_deb_cnt;
  mode_e            r_state;
  mode_e            w_next;
  logic [CNT_W-1:0] r_div_cnt;
  logic             r_phase;
  logic [1:0]       r_led;
  logic             w_step;
  logic             w_run;
  logic [CNT_W-1:0] w_div_last;
  logic [1:0]       w_pat;

  // Three-flop synchroniser for both asynchronous ARM lines.
  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      r_s0 <= 2'b00;
      r_s1 <= 2'b00;
      r_s2 <= 2'b00;
    end else begin
      r_s0 <= armgpio;
      r_s1 <= r_s0;
      r_s2 <= r_s1;
    end
  end

  // Debounce: a new level must persist DEB_CYC cycles before it is accepted.
  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      r_stable  <= 1'b0;
      r_deb_cnt <= '0;
    end else if (r_s2[1] == r_stable) begin
      r_deb_cnt <= '0;
    end else if (r_deb_cnt == DEB_LAST) begin
      r_stable  <= r_s2[1];
      r_deb_cnt <= '0;
    end else begin
      r_deb_cnt <= r_deb_cnt + CNT_ONE;
    end
  end

  // Delayed copy of the debounced level for rising-edge detection.
  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      r_stable_d <= 1'b0;
    end else begin
      r_stable_d <= r_stable;
    end
  end

  assign w_step = r_stable & ~r_stable_d;

  // Mode state register.
  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      r_state <= M_OFF;
    end else begin
      r_state <= w_next;
    end
  end

  // Mode sequencing; unused encodings fall back to OFF.
  always_comb begin
    w_next = r_state;
    case (r_state)
      M_OFF:   if (w_step) w_next = M_ON;
      M_ON:    if (w_step) w_next = M_SLOW;
      M_SLOW:  if (w_step) w_next = M_FAST;
      M_FAST:  if (w_step) w_next = M_ALT;
      M_ALT:   if (w_step) w_next = M_OFF;
      default: w_next = M_OFF;
    endcase
  end

  // Divider enable and half-period length for the current mode.
  always_comb begin
    w_run      = 1'b0;
    w_div_last = SLOW_LAST;
    case (r_state)
      M_SLOW, M_ALT: w_run = 1'b1;
      M_FAST: begin
        w_run      = 1'b1;
        w_div_last = FAST_LAST;
      end
      default: w_run = 1'b0;
    endcase
  end

  // Blink divider; a mode step restarts the pattern from phase 0.
  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      r_div_cnt <= '0;
      r_phase   <= 1'b0;
    end else if (w_step || !w_run) begin
      r_div_cnt <= '0;
      r_phase   <= 1'b0;
    end else if (r_div_cnt == w_div_last) begin
      r_div_cnt <= '0;
      r_phase   <= ~r_phase;
    end else begin
      r_div_cnt <= r_div_cnt + CNT_ONE;
    end
  end

  // LED pattern for the current mode and phase.
  always_comb begin
    w_pat = 2'b00;
    case (r_state)
      M_ON:           w_pat = 2'b11;
      M_SLOW, M_FAST: w_pat = {r_phase, r_phase};
      M_ALT:          w_pat = {~r_phase, r_phase};
      default:        w_pat = 2'b00;
    endcase
  end

  // Output register; the ARM override wins over the schedule.
  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      r_led <= 2'b00;
    end else if (r_s2[0]) begin
      r_led <= 2'b11;
    end else begin
      r_led <= w_pat;
    end
  end

  assign led  = r_led;
  assign mode = r_state;

endmodule
